clk_div_ctrl: RTL and testbench

Programmable controller for the team's clock-divider chain. It generates a divided square wave whose ratio is 2^(sel+1), selectable from /2 to /2^(2^SEL_W).
- Ratio changes are taken through a req/ack handshake and applied glitch-free, only at the end of a full output period.
- Enable/disable is drained cleanly, so the output never emits a runt pulse.
- Sits between the lab control logic (switches/FSM) and any logic clocked or enabled by divided clocks.

---
 rtl/clk_div_pkg.sv | 8 +
 rtl/clk_div_ctrl_if.sv | 13 +
 rtl/clk_div_counter.sv | 26 ++
 rtl/clk_div_ctrl.sv | 53 +++++
 tb/tb_clk_div_ctrl.sv | 124 ++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and helpers for the clock-divider controller
package clk_div_pkg;
  localparam int SEL_W_DEF = 3;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic int unsigned half_of(input int unsigned sel);
    return 32'd1 << sel;
  endfunction
endpackage

// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if: control/status bundle between lab control logic and the divider
interface clk_div_ctrl_if import clk_div_pkg::*; #(parameter int SEL_W = SEL_W_DEF);
  logic en;
  logic req;
  logic [SEL_W-1:0] div_sel;
  logic ack;
  logic clk_out;
  logic tick;
  logic [SEL_W-1:0] cur_sel;
  logic busy;
  modport master(output en, req, div_sel, input ack, clk_out, tick, cur_sel, busy);
  modport slave(input en, req, div_sel, output ack, clk_out, tick, cur_sel, busy);
endinterface

// File: rtl/clk_div_counter.sv
// clk_div_counter: half-period counter and output toggle register
module clk_div_counter #(parameter int CNT_W = 7) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  input  logic [CNT_W:0] half,
  output logic clk_out,
  output logic tick,
  output logic term
);
  logic [CNT_W-1:0] cnt;
  assign term = cnt == CNT_W'(half - 1'b1);
  always_ff @(posedge clk)
    if (!rst || clr) begin
      cnt <= '0;
      clk_out <= 1'b0;
      tick <= 1'b0;
    end else if (run) begin
      cnt <= term ? '0 : cnt + 1'b1;
      clk_out <= clk_out ^ term;
      tick <= term & ~clk_out;
    end else begin
      tick <= 1'b0;
    end
endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: glitch-free 2^(sel+1) divider with req/ack ratio changes and clean drain
module clk_div_ctrl import clk_div_pkg::*; #(
  parameter int SEL_W = SEL_W_DEF,
  parameter int RST_SEL = 0
) (
  input logic clk,
  input logic rst,
  clk_div_ctrl_if.slave bus
);
  localparam int CNT_W = 2**SEL_W - 1;
  localparam int HW = CNT_W + 1;
  localparam logic [SEL_W-1:0] RSEL = SEL_W'(RST_SEL);
  state_t state, nxt;
  logic pend, pend_nxt, term, fall, apply, run, clr, clk_o, tick_o;
  logic [SEL_W-1:0] pend_sel;
  logic [CNT_W:0] half;
  assign half = HW'(half_of(32'(bus.cur_sel)));
  assign run = state != IDLE;
  assign fall = run & clk_o & term;
  // a drain finishing on a low-phase terminal count must not raise clk_out
  assign clr = (state == DRAIN) & term & ~bus.en;
  assign apply = pend & ((state == IDLE) | fall);
  assign pend_nxt = bus.req | (pend & ~apply);
  assign nxt = bus.en ? RUN : ((state == IDLE) | clr) ? IDLE : DRAIN;
  assign bus.clk_out = clk_o;
  assign bus.tick = tick_o;
  clk_div_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .run(run),
    .clr(clr),
    .half(half),
    .clk_out(clk_o),
    .tick(tick_o),
    .term(term)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      pend <= 1'b0;
      pend_sel <= RSEL;
      bus.cur_sel <= RSEL;
      bus.ack <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      state <= nxt;
      pend <= pend_nxt;
      pend_sel <= bus.req ? bus.div_sel : pend_sel;
      bus.cur_sel <= apply ? pend_sel : bus.cur_sel;
      bus.ack <= apply;
      bus.busy <= pend_nxt | (nxt == DRAIN);
    end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: randomized scoreboard bench against a period-position reference model
module tb_clk_div_ctrl;
  localparam int SEL_W = 3;
  localparam int RST_SEL = 0;
  typedef struct packed {
    logic ack;
    logic clk_out;
    logic tick;
    logic busy;
    logic [SEL_W-1:0] cur_sel;
  } obs_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  clk_div_ctrl_if #(.SEL_W(SEL_W)) bus();
  clk_div_ctrl #(.SEL_W(SEL_W), .RST_SEL(RST_SEL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  obs_t exp_q[$];
  int compared = 0;
  int mismatched = 0;
  int cycle = 0;
  // model: mode 0 idle, 1 run, 2 drain; pos is the position inside the current period
  int mode = 0;
  int pos = 0;
  int sel = RST_SEL;
  int pend_sel = RST_SEL;
  bit pend = 1'b0;
  task automatic model(input logic r, input logic e, input logic q, input int d);
    int h;
    bit act, fall, lowend, apply;
    obs_t o;
    o = '0;
    if (!r) begin
      mode = 0;
      pos = 0;
      sel = RST_SEL;
      pend_sel = RST_SEL;
      pend = 1'b0;
    end else begin
      h = 1 << sel;
      act = mode != 0;
      fall = act && pos == 2 * h - 1;
      lowend = act && pos == h - 1;
      apply = pend && (!act || fall);
      o.ack = apply;
      if (!act) mode = e ? 1 : 0;
      else if (mode == 2 && !e && (fall || lowend)) begin
        mode = 0;
        pos = 0;
      end else begin
        pos = fall ? 0 : pos + 1;
        o.tick = pos == h;
        mode = e ? 1 : 2;
      end
      if (apply) sel = pend_sel;
      if (q) pend_sel = d;
      pend = q || (pend && !apply);
    end
    o.clk_out = pos >= (1 << sel);
    o.busy = pend || mode == 2;
    o.cur_sel = SEL_W'(sel);
    exp_q.push_back(o);
  endtask
  task automatic drive(input logic r, input logic e, input logic q, input int d);
    @(negedge clk);
    rst = r;
    bus.en = e;
    bus.req = q;
    bus.div_sel = SEL_W'(d);
    model(r, e, q, d);
  endtask
  initial begin
    obs_t got, want;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        got = {bus.ack, bus.clk_out, bus.tick, bus.busy, bus.cur_sel};
        compared++;
        if (got !== want) begin
          mismatched++;
          $display("FAIL cycle %0d: got ack=%b clk_out=%b tick=%b busy=%b cur_sel=%0d, want ack=%b clk_out=%b tick=%b busy=%b cur_sel=%0d",
            cycle, got.ack, got.clk_out, got.tick, got.busy, got.cur_sel,
            want.ack, want.clk_out, want.tick, want.busy, want.cur_sel);
        end
      end
    end
  end
  initial begin
    logic e, q, r;
    int d;
    bus.en = 1'b0;
    bus.req = 1'b0;
    bus.div_sel = '0;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 0);
    repeat (10) drive(1'b1, 1'b1, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 0);
    repeat (4) drive(1'b1, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b1, 2);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 0);
    repeat (20) drive(1'b1, 1'b1, 1'b0, 0);
    e = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 59) == 0) e = ~e;
      q = $urandom_range(0, 29) == 0;
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 2));
      r = $urandom_range(0, 799) != 0;
      drive(r, e, q, d);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain_queue: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
